// File: rtl/chrono_ctrl.sv
// Stopwatch front end: debounces KEY0/KEY1, runs the IDLE/RUN/STOP/LAP state machine and emits the tick_ms count enable.
// Define CHRONO_CTRL_LAP_EN to build the LAP state and lap_hold; otherwise lap only clears from STOP.
module chrono_ctrl #(
    parameter int CLK_FREQ    = 50000000,
    parameter int TICK_FREQ   = 1000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_start_n,
    input  logic key_lap_n,
    output logic tick_ms,
    output logic clear,
    output logic run,
    output logic lap_hold
);

    localparam int TICK_DIV  = CLK_FREQ / TICK_FREQ;
    localparam int DB_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int PS_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STOP,
        S_LAP
    } state_t;

    // Index 0 is the start key, index 1 the lap key.
    logic [1:0]      key_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      level;
    logic [1:0]      armed;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    assign key_raw = {key_lap_n, key_start_n};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
            level <= 2'b11;
            armed <= 2'b00;
            press <= 2'b00;
            // NOTE: the two debounce counters are plain flops, so resetting them costs nothing.
            for (int k = 0; k < 2; k++) db_cnt[k] <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            for (int k = 0; k < 2; k++) begin
                press[k] <= 1'b0;
                if (!armed[k]) begin
                    // A key held through reset must be seen released for a full window first.
                    if (!sync2[k]) begin
                        db_cnt[k] <= '0;
                    end else if (db_cnt[k] == DB_LAST) begin
                        armed[k]  <= 1'b1;
                        db_cnt[k] <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + DB_W'(1);
                    end
                end else if (sync2[k] == level[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    level[k]  <= sync2[k];
                    db_cnt[k] <= '0;
                    press[k]  <= ~sync2[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + DB_W'(1);
                end
            end
        end
    end

    state_t          state;
    state_t          next_state;
    logic            start_ev;
    logic            lap_ev;
    logic            running_now;
    logic            running_next;
    logic            advance;
    logic [PS_W-1:0] prescaler;

    assign start_ev = press[0];
    assign lap_ev   = press[1] & ~press[0];

    // NOTE: next_state gets its default first, so no path through the case can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start_ev) next_state = S_RUN;
            S_RUN: begin
                if (start_ev) next_state = S_STOP;
`ifdef CHRONO_CTRL_LAP_EN
                else if (lap_ev) next_state = S_LAP;
`endif
            end
            S_LAP: begin
`ifdef CHRONO_CTRL_LAP_EN
                if (start_ev)    next_state = S_STOP;
                else if (lap_ev) next_state = S_RUN;
`else
                next_state = S_IDLE;
`endif
            end
            S_STOP: begin
                if (start_ev)    next_state = S_RUN;
                else if (lap_ev) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    assign running_now  = (state == S_RUN) || (state == S_LAP);
    assign running_next = (next_state == S_RUN) || (next_state == S_LAP);
    // Counting only while running on both sides of the edge keeps STOP from eating or adding a cycle.
    assign advance      = running_now && running_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prescaler <= '0;
            tick_ms   <= 1'b0;
            clear     <= 1'b0;
            run       <= 1'b0;
        end else begin
            state   <= next_state;
            run     <= running_next;
            clear   <= (next_state == S_IDLE) && (state != S_IDLE);
            tick_ms <= advance && (prescaler == PS_LAST);
            if (next_state == S_IDLE) begin
                prescaler <= '0;
            end else if (advance) begin
                prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + PS_W'(1);
            end
        end
    end

`ifdef CHRONO_CTRL_LAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lap_hold <= 1'b0;
        else        lap_hold <= (next_state == S_LAP);
    end
`else
    assign lap_hold = 1'b0;
`endif

endmodule
